// File: rtl/vec_csr_unit_if.sv
// vec_csr_unit_if: request/response handshake between vec_decode and vec_csr_unit
interface vec_csr_unit_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_kind;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr_addr;
    logic            req_rs1_x0;
    logic            req_rd_x0;
    logic [XLEN-1:0] req_avl;
    logic [XLEN-1:0] req_vtype;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_illegal;
    modport master (
        output req_valid, req_kind, req_funct3, req_csr_addr, req_rs1_x0, req_rd_x0, req_avl, req_vtype, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_illegal
    );
    modport slave (
        input  req_valid, req_kind, req_funct3, req_csr_addr, req_rs1_x0, req_rd_x0, req_avl, req_vtype, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_illegal
    );
endinterface

// File: rtl/vec_csr_unit.sv
// vec_csr_unit: vset* configuration and vector Zicsr access unit driving lane configuration
module vec_csr_unit #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    vec_csr_unit_if.slave            bus,
    output logic                     cfg_done,
    input  logic                     vxsat_set,
    input  logic                     vstart_clr,
    output logic [2:0]               vsew,
    output logic [2:0]               vlmul,
    output logic                     vta,
    output logic                     vma,
    output logic                     vill,
    output logic [XLEN-1:0]          vl,
    output logic [$clog2(VLEN):0]    vlmax,
    output logic [$clog2(VLEN)-1:0]  vstart,
    output logic [1:0]               vxrm,
    output logic                     vxsat
);
    localparam int VLW = $clog2(VLEN) + 1;
    localparam int VSW = $clog2(VLEN);
    localparam logic [11:0] A_VSTART = 12'h008;
    localparam logic [11:0] A_VXSAT  = 12'h009;
    localparam logic [11:0] A_VXRM   = 12'h00A;
    localparam logic [11:0] A_VCSR   = 12'h00F;
    localparam logic [11:0] A_VL     = 12'hC20;
    localparam logic [11:0] A_VTYPE  = 12'hC21;
    localparam logic [11:0] A_VLENB  = 12'hC22;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t state, state_nxt;

    logic [1:0]      k_kind;
    logic [1:0]      k_op;
    logic [11:0]     k_addr;
    logic            k_rs1_x0;
    logic            k_rd_x0;
    logic [XLEN-1:0] k_avl;
    logic [XLEN-1:0] k_vtype;

    logic [2:0]      n_sew;
    logic [2:0]      n_lmul;
    logic [10:0]     sew_bits;
    logic [10:0]     elen_lmul;
    logic [VLW-1:0]  base;
    logic [VLW-1:0]  vlmax_raw;
    logic [VLW-1:0]  vlmax_new;
    logic [XLEN-1:0] vlmax_x;
    logic            vt_ill;
    logic [XLEN-1:0] vl_new;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;
    logic            csr_known;
    logic            csr_wr;
    logic            csr_ill;
    logic            csr_we;
    logic            set_we;

    assign bus.req_ready = state == IDLE;
    assign n_sew = k_vtype[5:3];
    assign n_lmul = k_vtype[2:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.req_valid ? CALC : IDLE;
            CALC:    state_nxt = RESP;
            RESP:    state_nxt = bus.resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // fractional LMUL shifts right by 8-vlmul, i.e. by -vlmul in 3 bits
    always_comb begin
        sew_bits = 11'd8 << n_sew;
        elen_lmul = n_lmul[2] ? 11'(ELEN) >> (3'd0 - n_lmul) : 11'(ELEN);
        base = VLW'(VLEN >> ({1'b0, n_sew} + 4'd3));
        vlmax_raw = n_lmul[2] ? base >> (3'd0 - n_lmul) : base << n_lmul[1:0];
        vt_ill = n_lmul == 3'd4 || n_sew[2] || sew_bits > 11'(ELEN) || (n_lmul[2] && sew_bits > elen_lmul) || |k_vtype[XLEN-1:8];
        vlmax_new = vt_ill ? '0 : vlmax_raw;
        vlmax_x = XLEN'(vlmax_new);
        vl_new = vt_ill ? '0 : (k_kind == 2'd1 || !k_rs1_x0) ? (k_avl < vlmax_x ? k_avl : vlmax_x) :
                 !k_rd_x0 ? vlmax_x : (vl > vlmax_x ? vlmax_x : vl);
    end

    always_comb begin
        csr_old = '0;
        csr_known = 1'b1;
        case (k_addr)
            A_VSTART: csr_old = XLEN'(vstart);
            A_VXSAT:  csr_old = XLEN'(vxsat);
            A_VXRM:   csr_old = XLEN'(vxrm);
            A_VCSR:   csr_old = XLEN'({vxrm, vxsat});
            A_VL:     csr_old = vl;
            A_VTYPE:  csr_old = {vill, {(XLEN-9){1'b0}}, vma, vta, vsew, vlmul};
            A_VLENB:  csr_old = XLEN'(VLEN / 8);
            default:  csr_known = 1'b0;
        endcase
    end

    assign csr_wr = k_op == 2'b01 || !k_rs1_x0;
    assign csr_ill = !csr_known || k_op == 2'b00 || (csr_wr && (k_addr == A_VL || k_addr == A_VTYPE || k_addr == A_VLENB));
    assign csr_new = k_op == 2'b01 ? k_avl : k_op == 2'b10 ? csr_old | k_avl : csr_old & ~k_avl;
    assign csr_we = state == CALC && k_kind == 2'd3 && !csr_ill && csr_wr;
    assign set_we = state == CALC && k_kind != 2'd3;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k_kind <= '0;
            k_op <= '0;
            k_addr <= '0;
            k_rs1_x0 <= 1'b0;
            k_rd_x0 <= 1'b0;
            k_avl <= '0;
            k_vtype <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            k_kind <= bus.req_kind;
            k_op <= bus.req_funct3[1:0];
            k_addr <= bus.req_csr_addr;
            k_rs1_x0 <= bus.req_rs1_x0;
            k_rd_x0 <= bus.req_rd_x0;
            k_avl <= bus.req_avl;
            k_vtype <= bus.req_vtype;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_illegal <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= set_we;
            if (state == CALC) begin
                bus.resp_valid <= 1'b1;
                bus.resp_rdata <= k_kind != 2'd3 ? vl_new : csr_ill ? '0 : csr_old;
                bus.resp_illegal <= k_kind == 2'd3 && csr_ill;
            end else if (state == RESP && bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end

    // datapath saturation ORs in after any same-cycle CSR write
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vill <= 1'b1;
            vsew <= '0;
            vlmul <= '0;
            vta <= 1'b0;
            vma <= 1'b0;
            vl <= '0;
            vlmax <= '0;
            vstart <= '0;
            vxrm <= '0;
            vxsat <= 1'b0;
        end else begin
            if (set_we) begin
                vill <= vt_ill;
                vsew <= vt_ill ? 3'd0 : n_sew;
                vlmul <= vt_ill ? 3'd0 : n_lmul;
                vta <= !vt_ill && k_vtype[6];
                vma <= !vt_ill && k_vtype[7];
                vl <= vl_new;
                vlmax <= vlmax_new;
            end
            vstart <= (csr_we && k_addr == A_VSTART) ? csr_new[VSW-1:0] : (set_we || vstart_clr) ? '0 : vstart;
            vxrm <= (csr_we && k_addr == A_VXRM) ? csr_new[1:0] : (csr_we && k_addr == A_VCSR) ? csr_new[2:1] : vxrm;
            vxsat <= ((csr_we && (k_addr == A_VXSAT || k_addr == A_VCSR)) ? csr_new[0] : vxsat) | vxsat_set;
        end
    end
endmodule

// File: tb/tb_vec_csr_unit.sv
// tb_vec_csr_unit: directed and randomized checks of vec_csr_unit against a behavioural model
module tb_vec_csr_unit;
    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int ELEN = 64;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    vec_csr_unit_if #(.XLEN(XLEN)) bus();
    logic cfg_done, vxsat_set, vstart_clr, vta, vma, vill, vxsat;
    logic [2:0] vsew, vlmul;
    logic [XLEN-1:0] vl;
    logic [9:0] vlmax;
    logic [8:0] vstart;
    logic [1:0] vxrm;

    vec_csr_unit #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .cfg_done(cfg_done), .vxsat_set(vxsat_set), .vstart_clr(vstart_clr),
        .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma), .vill(vill), .vl(vl), .vlmax(vlmax),
        .vstart(vstart), .vxrm(vxrm), .vxsat(vxsat)
    );

    int checks = 0;
    int errors = 0;

    logic        m_vill, m_vta, m_vma, m_vxsat;
    logic [2:0]  m_sew, m_lmul;
    logic [31:0] m_vl;
    int          m_vlmax;
    logic [8:0]  m_vstart;
    logic [1:0]  m_vxrm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vill = 1; m_vta = 0; m_vma = 0; m_vxsat = 0; m_sew = 0; m_lmul = 0;
        m_vl = 0; m_vlmax = 0; m_vstart = 0; m_vxrm = 0;
    endtask

    task automatic check_cfg(input string tag);
        check({tag, ".vill"}, vill, m_vill);
        check({tag, ".vsew"}, vsew, m_sew);
        check({tag, ".vlmul"}, vlmul, m_lmul);
        check({tag, ".vta"}, vta, m_vta);
        check({tag, ".vma"}, vma, m_vma);
        check({tag, ".vl"}, vl, m_vl);
        check({tag, ".vlmax"}, vlmax, m_vlmax);
        check({tag, ".vstart"}, vstart, m_vstart);
        check({tag, ".vxrm"}, vxrm, m_vxrm);
        check({tag, ".vxsat"}, vxsat, m_vxsat);
    endtask

    // VLMAX = LMUL*VLEN/SEW, legality checked as SEW <= ELEN*LMUL in whole numbers
    task automatic model_vset(input logic [1:0] kind, input logic rs1_x0, input logic rd_x0,
                              input logic [31:0] avl, input logic [31:0] vtype, output logic [31:0] rdata);
        int se, lm, sew, mx;
        bit ill;
        se = int'(vtype[5:3]);
        lm = int'(vtype[2:0]);
        sew = 8 << se;
        ill = lm == 4 || se > 3 || vtype[31:8] != 0 || sew > ELEN || (lm > 4 && sew * (1 << (8 - lm)) > ELEN);
        if (ill) begin
            m_vill = 1; m_sew = 0; m_lmul = 0; m_vta = 0; m_vma = 0; m_vl = 0; m_vlmax = 0;
        end else begin
            mx = lm < 4 ? (VLEN * (1 << lm)) / sew : VLEN / sew / (1 << (8 - lm));
            m_vill = 0; m_sew = vtype[5:3]; m_lmul = vtype[2:0]; m_vta = vtype[6]; m_vma = vtype[7];
            m_vlmax = mx;
            if (kind == 1 || !rs1_x0) m_vl = avl < 32'(mx) ? avl : 32'(mx);
            else if (!rd_x0) m_vl = 32'(mx);
            else m_vl = m_vl < 32'(mx) ? m_vl : 32'(mx);
        end
        m_vstart = 0;
        rdata = m_vl;
    endtask

    task automatic model_csr(input logic [2:0] f3, input logic [11:0] addr, input logic rs1_x0, input logic [31:0] data,
                             input logic clr, output logic [31:0] rdata, output logic ill);
        logic [31:0] old, nv;
        bit known, wr, vs_wr;
        int op;
        known = 1;
        vs_wr = 0;
        case (addr)
            12'h008: old = 32'(m_vstart);
            12'h009: old = 32'(m_vxsat);
            12'h00A: old = 32'(m_vxrm);
            12'h00F: old = 32'({m_vxrm, m_vxsat});
            12'hC20: old = m_vl;
            12'hC21: old = {m_vill, 23'd0, m_vma, m_vta, m_sew, m_lmul};
            12'hC22: old = VLEN / 8;
            default: begin old = 0; known = 0; end
        endcase
        op = int'(f3[1:0]);
        wr = op == 1 || !rs1_x0;
        ill = !known || op == 0 || (wr && (addr == 12'hC20 || addr == 12'hC21 || addr == 12'hC22));
        rdata = ill ? 0 : old;
        if (!ill && wr) begin
            nv = op == 1 ? data : op == 2 ? (old | data) : (old & ~data);
            if (addr == 12'h008) begin m_vstart = nv[8:0]; vs_wr = 1; end
            if (addr == 12'h009) m_vxsat = nv[0];
            if (addr == 12'h00A) m_vxrm = nv[1:0];
            if (addr == 12'h00F) begin m_vxrm = nv[2:1]; m_vxsat = nv[0]; end
        end
        if (clr && !vs_wr) m_vstart = 0;
    endtask

    task automatic run_req(input string tag, input logic [1:0] kind, input logic [2:0] f3, input logic [11:0] addr,
                           input logic rs1_x0, input logic rd_x0, input logic [31:0] avl, input logic [31:0] vtype,
                           input logic sat, input logic clr, input int hold);
        logic [31:0] e_rdata;
        logic e_ill;
        int n;
        @(negedge clk);
        check({tag, ".ready_idle"}, bus.req_ready, 1);
        bus.req_kind = kind; bus.req_funct3 = f3; bus.req_csr_addr = addr; bus.req_rs1_x0 = rs1_x0;
        bus.req_rd_x0 = rd_x0; bus.req_avl = avl; bus.req_vtype = vtype; bus.req_valid = 1;
        @(negedge clk);
        bus.req_valid = 0;
        check({tag, ".ready_calc"}, bus.req_ready, 0);
        check({tag, ".valid_calc"}, bus.resp_valid, 0);
        vxsat_set = sat;
        vstart_clr = clr;
        e_ill = 0;
        if (kind != 3) model_vset(kind, rs1_x0, rd_x0, avl, vtype, e_rdata);
        else model_csr(f3, addr, rs1_x0, avl, clr, e_rdata, e_ill);
        if (sat) m_vxsat = 1;
        n = 1;
        while (!bus.resp_valid && n < 8) begin
            @(negedge clk);
            n++;
            vxsat_set = 0;
            vstart_clr = 0;
        end
        check({tag, ".latency"}, n, 2);
        check({tag, ".rdata"}, bus.resp_rdata, e_rdata);
        check({tag, ".illegal"}, bus.resp_illegal, e_ill);
        check({tag, ".cfg_done"}, cfg_done, kind != 3);
        check_cfg(tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, bus.resp_valid, 1);
            check({tag, ".hold_rdata"}, bus.resp_rdata, e_rdata);
            check({tag, ".hold_illegal"}, bus.resp_illegal, e_ill);
            check({tag, ".hold_ready"}, bus.req_ready, 0);
            check({tag, ".hold_cfg_done"}, cfg_done, 0);
        end
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
        check({tag, ".valid_done"}, bus.resp_valid, 0);
        check({tag, ".ready_done"}, bus.req_ready, 1);
        check({tag, ".cfg_done_off"}, cfg_done, 0);
    endtask

    initial begin
        logic [11:0] addrs [8] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22, 12'h123};
        logic [31:0] vt, av;
        logic [1:0] kd;
        bus.req_valid = 0; bus.req_kind = 0; bus.req_funct3 = 0; bus.req_csr_addr = 0; bus.req_rs1_x0 = 0;
        bus.req_rd_x0 = 0; bus.req_avl = 0; bus.req_vtype = 0; bus.resp_ready = 0;
        vxsat_set = 0; vstart_clr = 0;
        model_reset();
        #12 n_rst = 1;
        @(negedge clk);
        check("reset.req_ready", bus.req_ready, 1);
        check("reset.resp_valid", bus.resp_valid, 0);
        check_cfg("reset");

        run_req("vsetvli_e32m2", 0, 0, 0, 0, 0, 100, 32'h11, 0, 0, 0);
        check("vsetvli_e32m2.vl32", vl, 32);
        run_req("vsetvli_mf2_x0", 0, 0, 0, 1, 0, 0, 32'h07, 0, 0, 0);
        run_req("vsetvl_lmul4", 2, 0, 0, 0, 0, 50, 32'h04, 0, 0, 0);
        check("vsetvl_lmul4.vill", vill, 1);
        run_req("csrrw_vstart", 3, 3'b001, 12'h008, 0, 0, 32'h25, 0, 0, 0, 0);
        check("csrrw_vstart.val", vstart, 9'h25);
        run_req("csrrs_vl", 3, 3'b010, 12'hC20, 0, 0, 1, 0, 0, 0, 0);
        run_req("csrrc_vxsat", 3, 3'b011, 12'h009, 0, 0, 1, 0, 1, 0, 5);
        check("csrrc_vxsat.sat", vxsat, 1);
        run_req("vsetivli_e64m8", 1, 0, 0, 0, 0, 31, 32'hDB, 0, 1, 1);
        run_req("csrrw_vstart_clr", 3, 3'b101, 12'h008, 0, 0, 32'h3FF, 0, 0, 1, 0);

        @(negedge clk);
        bus.req_kind = 0; bus.req_rs1_x0 = 0; bus.req_rd_x0 = 0; bus.req_avl = 8; bus.req_vtype = 32'h00;
        bus.req_valid = 1;
        @(negedge clk);
        bus.req_valid = 0;
        n_rst = 0;
        model_reset();
        #1;
        check("rst_calc.resp_valid", bus.resp_valid, 0);
        check("rst_calc.req_ready", bus.req_ready, 1);
        check("rst_calc.cfg_done", cfg_done, 0);
        check_cfg("rst_calc");
        @(negedge clk);
        n_rst = 1;
        repeat (2) @(negedge clk);
        check("rst_calc.idle_valid", bus.resp_valid, 0);
        check_cfg("rst_after");

        for (int it = 0; it < 200; it++) begin
            kd = 2'($urandom_range(0, 3));
            vt = 32'({2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7))});
            if ($urandom_range(0, 9) == 0) vt = vt | (32'd1 << $urandom_range(8, 31));
            av = kd == 1 ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 700));
            run_req("rand", kd, 3'($urandom_range(0, 7)), addrs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), av, vt, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
